// File: rtl/lifi_codeword_rx.sv
// ============================================================================
// Module   : lifi_codeword_rx
// Purpose  : Oversampling UART-style framer that assembles Hamming codewords
//            for hamming_decoder. Optional LIFI_RX_MAJORITY_EN enables 2-of-3
//            majority bit decisions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lifi_codeword_rx #(
  parameter int OVS       = 8,
  parameter int CW_W      = 7,
  parameter int STOP_BITS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_in,
  input  logic            enable,
  input  logic            dec_ready,
  output logic [CW_W-1:0] codeword,
  output logic            valid,
  output logic            busy,
  output logic            frame_err,
  output logic            overrun
);

  localparam int c_sw = $clog2(OVS);
  localparam int c_bw = (CW_W > 1) ? $clog2(CW_W) : 1;
  localparam logic [c_sw-1:0] c_scnt_max  = c_sw'(OVS - 1);
  localparam logic [c_bw-1:0] c_bcnt_last = c_bw'(CW_W - 1);
  localparam logic            c_stop_last = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_sync1;
  logic            r_rx_s;
  logic            r_rx_prev;
  logic [c_sw-1:0] r_scnt;
  logic [c_bw-1:0] r_bcnt;
  logic            r_stopcnt;
  logic [CW_W-1:0] r_sr;
  logic [CW_W-1:0] r_codeword;
  logic            r_valid;
  logic            r_frame_err;
  logic            r_overrun;
  logic            r_pending;
  logic            w_tick;
  logic            w_bit;
  logic            w_pend_hold;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1   <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= rx_in;
      r_rx_s    <= r_sync1;
      r_rx_prev <= r_rx_s;
    end
  end

`ifdef LIFI_RX_MAJORITY_EN
  // Window is scnt = OVS/2-2 .. OVS/2; the vote is taken when scnt reaches OVS/2.
  localparam logic [c_sw-1:0] c_decide = c_sw'(OVS / 2);
  logic [1:0] r_hist;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hist <= 2'b11;
    end else begin
      r_hist <= {r_hist[0], r_rx_s};
    end
  end

  assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_rx_s) | (r_hist[0] & r_rx_s);
`else
  localparam logic [c_sw-1:0] c_decide = c_sw'(OVS / 2 - 1);
  assign w_bit = r_rx_s;
`endif

  // scnt free-runs from START entry, so every wrap lands on the next bit centre.
  assign w_tick      = (r_scnt == c_decide);
  assign w_pend_hold = r_pending & ~(dec_ready & ~r_valid);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_scnt      <= '0;
      r_bcnt      <= '0;
      r_stopcnt   <= 1'b0;
      r_sr        <= '0;
      r_codeword  <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_pending   <= 1'b0;
    end else begin
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_pending   <= w_pend_hold;
      r_scnt      <= (r_scnt == c_scnt_max) ? '0 : r_scnt + 1'b1;
      if (!enable) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (r_rx_prev && !r_rx_s) begin
              r_state <= S_START;
              r_scnt  <= '0;
            end
          end
          S_START: begin
            if (w_tick) begin
              if (w_bit) begin
                r_state <= S_IDLE;
              end else begin
                r_state <= S_DATA;
                r_bcnt  <= '0;
              end
            end
          end
          S_DATA: begin
            if (w_tick) begin
              r_sr[r_bcnt] <= w_bit;
              if (r_bcnt == c_bcnt_last) begin
                r_state   <= S_STOP;
                r_stopcnt <= 1'b0;
              end else begin
                r_bcnt <= r_bcnt + 1'b1;
              end
            end
          end
          S_STOP: begin
            if (w_tick) begin
              if (!w_bit) begin
                r_frame_err <= 1'b1;
                r_state     <= S_IDLE;
              end else if (r_stopcnt == c_stop_last) begin
                r_state <= S_IDLE;
                if (w_pend_hold) begin
                  r_overrun <= 1'b1;
                end else begin
                  r_codeword <= r_sr;
                  r_valid    <= 1'b1;
                  r_pending  <= 1'b1;
                end
              end else begin
                r_stopcnt <= r_stopcnt + 1'b1;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign codeword  = r_codeword;
  assign valid     = r_valid;
  assign busy      = (r_state != S_IDLE);
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_lifi_codeword_rx.sv
// ============================================================================
// Module   : tb_lifi_codeword_rx
// Purpose  : Scoreboard bench for lifi_codeword_rx with directed frames.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lifi_codeword_rx;

  localparam int OVS       = 8;
  localparam int CW_W      = 7;
  localparam int STOP_BITS = 1;
  localparam int c_full    = (1 + CW_W + STOP_BITS) * OVS;

`ifdef LIFI_RX_MAJORITY_EN
  localparam int         c_lat       = 71;
  localparam logic [6:0] c_glitch_cw = 7'h7F;
`else
  localparam int         c_lat       = 70;
  localparam logic [6:0] c_glitch_cw = 7'h77;
`endif

  localparam int K_NONE  = 0;
  localparam int K_VALID = 1;
  localparam int K_FERR  = 2;
  localparam int K_OVR   = 3;

  typedef struct {
    int         kind;
    logic [6:0] cw;
    int         t0;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  logic       clk       = 1'b0;
  logic       reset     = 1'b0;
  logic       rx_in     = 1'b1;
  logic       enable    = 1'b1;
  logic       dec_ready = 1'b1;
  logic [6:0] codeword;
  logic       valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lifi_codeword_rx #(
    .OVS      (OVS),
    .CW_W     (CW_W),
    .STOP_BITS(STOP_BITS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_in    (rx_in),
    .enable   (enable),
    .dec_ready(dec_ready),
    .codeword (codeword),
    .valid    (valid),
    .busy     (busy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives up to len oversampled line cycles of one frame, then returns the line to idle.
  task automatic send_frame(input logic [6:0] cw, input logic stop_val, input int glitch_at,
                            input int len, input int kind, input logic [6:0] exp_cw);
    logic [8:0] bits;
    exp_t       e;
    bits = {stop_val, cw, 1'b0};
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      rx_in = (i == glitch_at) ? 1'b0 : bits[i / OVS];
      if (i == 0 && kind != K_NONE) begin
        e.kind = kind;
        e.cw   = exp_cw;
        e.t0   = cyc;
        sb.push_back(e);
      end
    end
    @(negedge clk);
    rx_in = 1'b1;
  endtask

  exp_t m_e;
  int   m_k;
  int   m_lat;
  logic ovr_q   = 1'b0;
  logic valid_q = 1'b0;

  always @(negedge clk) begin
    if (valid) check("valid_pulse_width", {31'd0, valid_q}, 32'd0);
    if (valid || frame_err || (overrun && !ovr_q)) begin
      m_k = valid ? K_VALID : (frame_err ? K_FERR : K_OVR);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: kind %0d codeword %0h, none expected", m_k, codeword);
      end else begin
        m_e = sb.pop_front();
        check("event_kind", m_k, m_e.kind);
        check("event_codeword", {25'd0, codeword}, {25'd0, m_e.cw});
        if (m_k == K_VALID) begin
          m_lat = cyc - m_e.t0;
          n_checks++;
          if (m_lat < c_lat - 1 || m_lat > c_lat + 1) begin
            n_fail++;
            $display("FAIL latency: got %0d cycles, expected %0d +/-1", m_lat, c_lat);
          end
        end
      end
    end
    ovr_q   <= overrun;
    valid_q <= valid;
  end

  initial begin
    @(negedge clk);
    check("reset_codeword", {25'd0, codeword}, 32'd0);
    check("reset_flags", {28'd0, valid, busy, frame_err, overrun}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    idle(4);

    send_frame(7'b1011001, 1'b1, -1, c_full, K_VALID, 7'b1011001);
    idle(6);

    // Two-cycle low glitch on an idle line
    @(negedge clk); rx_in = 1'b0;
    @(negedge clk);
    @(negedge clk); rx_in = 1'b1;
    @(negedge clk);
    check("false_start_busy_rise", {31'd0, busy}, 32'd1);
    idle(8);
    check("false_start_busy_fall", {31'd0, busy}, 32'd0);
    idle(4);

    send_frame(7'h55, 1'b0, -1, c_full, K_FERR, 7'b1011001);
    idle(6);

    send_frame(7'h11, 1'b1, -1, 30, K_NONE, 7'h00);
    enable = 1'b0;
    @(negedge clk);
    check("enable_drop_busy", {31'd0, busy}, 32'd0);
    enable = 1'b1;
    idle(80);
    check("enable_drop_codeword", {25'd0, codeword}, {25'd0, 7'b1011001});

    send_frame(7'h7F, 1'b1, 8 * 4 + OVS / 2, c_full, K_VALID, c_glitch_cw);
    idle(6);

    dec_ready = 1'b0;
    send_frame(7'h0F, 1'b1, -1, c_full, K_VALID, 7'h0F);
    send_frame(7'h70, 1'b1, -1, c_full, K_OVR, 7'h0F);
    idle(4);
    check("overrun_codeword_held", {25'd0, codeword}, {25'd0, 7'h0F});
    dec_ready = 1'b1;
    idle(2);
    send_frame(7'h2A, 1'b1, -1, c_full, K_VALID, 7'h2A);
    idle(6);
    check("overrun_sticky", {31'd0, overrun}, 32'd1);

    send_frame(7'h4C, 1'b1, -1, 44, K_NONE, 7'h00);
    reset = 1'b0;
    #1;
    check("midreset_codeword", {25'd0, codeword}, 32'd0);
    check("midreset_flags", {28'd0, valid, busy, frame_err, overrun}, 32'd0);
    idle(2);
    reset = 1'b1;
    idle(4);
    send_frame(7'h33, 1'b1, -1, c_full, K_VALID, 7'h33);
    idle(10);

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lifi_codeword_rx.md
Name: lifi_codeword_rx

Overview:
- Receive-side framing stage of the Li-Fi link. Sits directly upstream of hamming_decoder.
- Oversamples the photodiode comparator bit stream (UART-style framing) and assembles 7-bit Hamming codewords.
- Hands each codeword to the decoder with a one-cycle valid pulse, then waits for the decoder's ready before handing over the next.
- Flags framing errors and overruns.

Parameters:
- OVS, 8, clocks per line bit; even, >= 4.
- CW_W, 7, codeword width in bits; must match hamming_decoder.
- STOP_BITS, 1, number of stop bits checked (1 or 2).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous active-low reset; 0 = reset
- rx_in  in  1  raw serial line from comparator; asynchronous; idle high
- enable  in  1  1 = receiver armed; 0 = forced to IDLE at the next edge
- dec_ready  in  1  ready from hamming_decoder; high means the previous codeword has been consumed
- codeword  out  CW_W  assembled codeword; bit 0 = first bit received; held stable between valid pulses
- valid  out  1  one-cycle pulse; codeword is new
- busy  out  1  high in any state other than IDLE
- frame_err  out  1  one-cycle pulse on a bad stop bit
- overrun  out  1  sticky; set on a dropped codeword

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE; codeword=0, valid=0, busy=0, frame_err=0, overrun=0.
  - pending=0; synchroniser flops=1; counters=0.
  - Reset mid-frame discards the partial codeword.
- rx_in passes through a 2-FF synchroniser, giving rx_s (2-cycle input latency).
- Sample counter scnt runs 0..OVS-1. Mid-bit sample point is scnt==OVS/2-1.
- IDLE:
  - Go to START when enable=1 and rx_s falls from 1 to 0; scnt=0 on entry.
- START:
  - At the mid point, rx_s=0 confirms the start bit: go to DATA with scnt=0 and bcnt=0.
  - At the mid point, rx_s=1 is a false start: return to IDLE with no flags.
  - The first data sample lands OVS clocks after the confirm.
- DATA:
  - At each mid point, shift the sample in LSB-first: sr[bcnt]=sample, then bcnt++.
  - After bcnt reaches CW_W-1 and that bit is sampled, go to STOP.
- STOP:
  - Sample at the mid point of each stop bit.
  - Any sampled 0: frame_err=1 for one cycle, codeword discarded, go to IDLE.
  - All sampled 1: deliver the codeword, go to IDLE. IDLE accepts a new falling edge from the very next cycle.
- Delivery, in the cycle after the last stop-bit sample:
  - pending=0: codeword<=sr, valid=1 for exactly one cycle, pending=1.
  - pending=1: codeword unchanged, no valid, overrun<=1 (sticky until reset).
- pending clears in any cycle where dec_ready=1, excluding the valid cycle itself.
- Simultaneous events:
  - dec_ready=1 in the same cycle a delivery is decided: the clear is applied first, so the new codeword is delivered and there is no overrun.
  - enable falling mid-frame: return to IDLE, no valid, no frame_err. The codeword register keeps its old value.
- Latency: valid rises (2 + OVS/2 + (CW_W+STOP_BITS)·OVS) cycles after the start-bit falling edge on rx_in. For OVS=8, CW_W=7, STOP_BITS=1 this is 70 cycles (±1 for edge alignment).
- Width rules:
  - scnt is clog2(OVS) bits; bcnt is clog2(CW_W) bits.
  - Counters wrap to 0 at OVS-1 and never overflow.

Optional Feature:
- Macro: LIFI_RX_MAJORITY_EN.
- Defined:
  - Each bit decision is the 2-of-3 majority of rx_s at scnt = OVS/2-2, OVS/2-1 and OVS/2.
  - The decision is registered at OVS/2, so all decision points shift +1 cycle. Latency becomes 71 for the default parameters.
  - Applies to the start, data and stop bits.
  - A single-cycle glitch inside a bit does not corrupt it.
- Undefined: single sample at OVS/2-1, exactly as described in Behaviour.

Test Plan:
- Reset then clean frame:
  - Stimulus: reset low 2 cycles then high; drive start 0, codeword 7'b1011001 LSB-first, stop 1, OVS=8.
  - Response: valid pulses once, 70 cycles after the falling edge; codeword=7'b1011001; frame_err=0.
- False start:
  - Stimulus: 0-glitch of 2 cycles on an idle line.
  - Response: returns to IDLE, busy deasserts within 8 cycles, no valid, no frame_err.
- Bad stop:
  - Stimulus: frame 7'h55 with stop bit 0.
  - Response: frame_err pulses 1 cycle; no valid; codeword keeps its previous value.
- Handshake and overrun:
  - Stimulus: two back-to-back frames 7'h0F and 7'h70 with dec_ready held 0.
  - Response: first gives valid and codeword=7'h0F; second sets overrun=1 with no valid and codeword still 7'h0F.
  - Then raise dec_ready and send 7'h2A: valid, codeword=7'h2A, overrun stays 1.
- Reset mid-operation:
  - Stimulus: assert reset during data bit 4, then send 7'h33.
  - Response: all outputs 0 immediately; after release, 7'h33 is received correctly.
- Majority (macro defined):
  - Stimulus: frame 7'h7F with a 1-cycle 0 glitch at the mid point of bit 3.
  - Response: codeword=7'h7F.
  - Without the macro, the same stimulus gives 7'h77.
